// File: rtl/prime_disp_pkg.sv
// Shared types and constants for the prime display back-end:
// converter states, digit geometry and 7-segment codes (active low, dp off).
package prime_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_DONE
    } conv_state_e;

    localparam int NUM_DIGITS = 8;
    localparam int BCD_DIGITS = 7;
    localparam int BIN_W      = 20;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    // Segment order {dp,g,f,e,d,c,b,a}, active low; dp is always off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // BCD digit to segment pattern; nibbles above 9 never reach here.
    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction: add 3 to every nibble that is 5 or more,
    // so the following left shift carries correctly into the next digit.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/prime_display_driver_bin2bcd.sv
// Sequential binary-to-BCD converter (double dabble), one bit per cycle.
// start_i is taken only while idle; done_o is high for the single DONE cycle,
// during which result_o holds the finished conversion.
module bin2bcd_seq
    import prime_disp_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [BCD_W-1:0] result_o
);

    localparam logic [4:0] LAST_ITER = 5'(BIN_W - 1);

    conv_state_e      state_q;
    logic [BIN_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic [4:0]       cnt_q;
    logic [BCD_W-1:0] bcd_adj;

    // Correction step applied before every shift.
    always_comb begin
        bcd_adj = dabble_adjust(bcd_q);
    end

    // Converter FSM: latch on start, 20 adjust-and-shift iterations, one DONE cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        bin_q   <= bin_i;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                    bin_q <= {bin_q[BIN_W-2:0], 1'b0};
                    if (cnt_q == LAST_ITER) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = bcd_q;

endmodule

// File: rtl/prime_display_driver.sv
// Display back-end for the prime sieve: accepts a 20-bit prime, converts it to
// 7 BCD digits and scans it onto an 8-digit common-anode 7-segment display
// with optional leading-zero blanking. Digit 7 is always dark.
module prime_display_driver
    import prime_disp_pkg::*;
#(
    parameter int SCAN_DIV      = 50_000,
    parameter int BLANK_LEADING = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [BIN_W-1:0] prime_num,
    input  logic             prime_valid,
    output logic             prime_ready,
    output logic [BCD_W-1:0] bcd_out,
    output logic             bcd_valid,
    output logic [7:0]       seg,
    output logic [7:0]       an
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic             conv_busy;
    logic             conv_done;
    logic [BCD_W-1:0] conv_result;

    logic [BCD_W-1:0] bcd_out_q;
    logic             bcd_valid_q;
    logic [BCD_W-1:0] disp_q;
    logic             disp_loaded_q;

    logic [DIV_W-1:0] div_q;
    logic [2:0]       idx_q;
    logic [2:0]       idx_nx;
    logic [7:0]       an_q;
    logic [7:0]       seg_q;

    logic [NUM_DIGITS-1:0][7:0] digit_seg;
    logic                       upper_zero;

    assign prime_ready = !conv_busy;

    bin2bcd_seq u_conv (
        .clk      (clk),
        .rstn     (rstn),
        .start_i  (prime_valid && !conv_busy),
        .bin_i    (prime_num),
        .busy_o   (conv_busy),
        .done_o   (conv_done),
        .result_o (conv_result)
    );

    // Capture the finished conversion for the output port and the display.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bcd_out_q     <= '0;
            bcd_valid_q   <= 1'b0;
            disp_q        <= '0;
            disp_loaded_q <= 1'b0;
        end else begin
            bcd_valid_q <= conv_done;
            if (conv_done) begin
                bcd_out_q     <= conv_result;
                disp_q        <= conv_result;
                disp_loaded_q <= 1'b1;
            end
        end
    end

    // Per-digit segment patterns; walk from the top digit down so a digit is
    // blanked only while everything above it is also zero. Digit 0 always shows.
    always_comb begin
        digit_seg  = {NUM_DIGITS{SEG_BLANK}};
        upper_zero = 1'b1;
        for (int k = BCD_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (disp_q[4*k +: 4] == 4'd0);
            if (!disp_loaded_q)
                digit_seg[k] = SEG_BLANK;
            else if ((BLANK_LEADING != 0) && (k != 0) && upper_zero)
                digit_seg[k] = SEG_BLANK;
            else
                digit_seg[k] = seg_code(disp_q[4*k +: 4]);
        end
    end

    assign idx_nx = idx_q + 3'd1;

    // Scan divider: on wrap step to the next digit and register its enable and segments.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q <= '0;
            idx_q <= 3'd7;
            an_q  <= 8'hFF;
            seg_q <= SEG_BLANK;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            idx_q <= idx_nx;
            an_q  <= ~(8'h01 << idx_nx);
            seg_q <= digit_seg[idx_nx];
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign bcd_out   = bcd_out_q;
    assign bcd_valid = bcd_valid_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_prime_display_driver.sv
// Randomized scoreboard bench: two instances (blanking on / off) share stimulus.
// Accepts push the expected decimal conversion; a negedge monitor compares
// handshake, BCD result and the scanned display against an arithmetic model.
module tb_prime_display_driver;

    localparam int SD = 4;
    localparam int LAT = 21;
    localparam logic [7:0] SEGT [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [19:0] prime_num = '0;
    logic        prime_valid = 1'b0;

    logic        ready0, ready1, bv0, bv1;
    logic [27:0] bcd0, bcd1;
    logic [7:0]  seg0, seg1, an0, an1;

    prime_display_driver #(.SCAN_DIV(SD), .BLANK_LEADING(1)) dut0 (
        .clk(clk), .rstn(rstn), .prime_num(prime_num), .prime_valid(prime_valid),
        .prime_ready(ready0), .bcd_out(bcd0), .bcd_valid(bv0), .seg(seg0), .an(an0));

    prime_display_driver #(.SCAN_DIV(SD), .BLANK_LEADING(0)) dut1 (
        .clk(clk), .rstn(rstn), .prime_num(prime_num), .prime_valid(prime_valid),
        .prime_ready(ready1), .bcd_out(bcd1), .bcd_valid(bv1), .seg(seg1), .an(an1));

    always #5 clk = ~clk;

    typedef struct {
        int unsigned val;
        int          cyc;
    } txn_t;

    txn_t        q[$];
    txn_t        tx;
    int          cyc = 0;
    int          t = 0;
    int          kslot = 0;
    int unsigned disp_val = 0;
    bit          loaded = 1'b0;
    bit          done_now = 1'b0;
    logic [27:0] exp_last = '0;
    logic [7:0]  exp_an = 8'hFF, exp_seg0 = 8'hFF, exp_seg1 = 8'hFF;
    bit          exp_ready;
    int          tests = 0, fails = 0;

    function automatic logic [27:0] to_bcd(input int unsigned v);
        logic [27:0] r;
        int unsigned x;
        x = v;
        r = '0;
        for (int i = 0; i < 7; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_digit(input int unsigned v, input bit ld,
                                             input int k, input bit blank);
        int unsigned p;
        p = 1;
        if (k >= 7 || !ld) return 8'hFF;
        for (int i = 0; i < k; i++) p = p * 10;
        if (blank && k > 0 && v < p) return 8'hFF;
        return SEGT[(v / p) % 10];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: scan slots from elapsed cycles, display/result update LAT edges after accept.
    always @(posedge clk) begin
        cyc++;
        done_now = 1'b0;
        if (!rstn) begin
            t = 0;
            q.delete();
            loaded = 1'b0;
            disp_val = 0;
            exp_last = '0;
            exp_an = 8'hFF;
            exp_seg0 = 8'hFF;
            exp_seg1 = 8'hFF;
        end else begin
            t++;
            if (t % SD == 0) begin
                kslot = (t / SD - 1) % 8;
                exp_an = ~(8'h01 << kslot);
                exp_seg0 = exp_digit(disp_val, loaded, kslot, 1'b1);
                exp_seg1 = exp_digit(disp_val, loaded, kslot, 1'b0);
            end
            if (q.size() > 0 && cyc == q[0].cyc + LAT) begin
                done_now = 1'b1;
                disp_val = q[0].val;
                loaded = 1'b1;
                exp_last = to_bcd(q[0].val);
            end
            if (prime_valid && ready0) begin
                tx.val = prime_num;
                tx.cyc = cyc;
                q.push_back(tx);
            end
        end
    end

    // Monitor: compare every output of both instances away from the active edge.
    always @(negedge clk) begin
        if (rstn) begin
            exp_ready = (q.size() == 0) || (cyc > q[0].cyc + LAT - 1);
            check("prime_ready0", 32'(ready0), 32'(exp_ready));
            check("prime_ready1", 32'(ready1), 32'(exp_ready));
            check("bcd_valid0", 32'(bv0), 32'(done_now));
            check("bcd_valid1", 32'(bv1), 32'(done_now));
            if (done_now) void'(q.pop_front());
            check("bcd_out0", 32'(bcd0), 32'(exp_last));
            check("bcd_out1", 32'(bcd1), 32'(exp_last));
            check("an0", 32'(an0), 32'(exp_an));
            check("an1", 32'(an1), 32'(exp_an));
            check("seg_blank", 32'(seg0), 32'(exp_seg0));
            check("seg_noblank", 32'(seg1), 32'(exp_seg1));
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready0), 32'd1);
        check({tag, "_bcd"}, 32'(bcd0), 32'd0);
        check({tag, "_bcd_valid"}, 32'(bv0), 32'd0);
        check({tag, "_seg"}, 32'(seg0), 32'hFF);
        check({tag, "_an"}, 32'(an0), 32'hFF);
        check({tag, "_seg1"}, 32'(seg1), 32'hFF);
    endtask

    // Present a value and hold it until accepted; called and returns at a negedge.
    task automatic send(input logic [19:0] v, input bit keep);
        int n;
        n = 0;
        prime_num = v;
        prime_valid = 1'b1;
        while (!ready0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: value %0d not accepted within %0d cycles", v, n);
            prime_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            if (!keep) prime_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check_reset_outputs("reset");
        rstn = 1'b1;
        idle(40);

        send(20'd1048573, 1'b0); idle(40);
        send(20'd2, 1'b0);       idle(40);
        send(20'd0, 1'b0);       idle(40);
        send(20'd7, 1'b0);       idle(40);

        // valid held high across three values
        send(20'd2, 1'b1);
        send(20'd3, 1'b1);
        send(20'd5, 1'b0);
        idle(40);

        // abort mid-conversion
        send(20'd123456, 1'b0);
        idle(10);
        #2 rstn = 1'b0;
        #1 check_reset_outputs("abort");
        idle(2);
        rstn = 1'b1;
        send(20'd999999, 1'b0);
        idle(40);

        repeat (25) begin
            send(20'($urandom_range(0, 1048575)), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 30));
        end
        prime_valid = 1'b0;
        send(20'd1048575, 1'b0);
        idle(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
